// File: rtl/cdrive_sync_receiver.sv
// Clocked receiver for the 2-phase drive/free handshake. Each i_drive transition offers one
// bundled word; it is synchronized, written into a small FIFO and presented on a valid/ready
// port. The o_free acknowledge is withheld while the FIFO is full.
// Optional build macro CDRV_RX_ERR_EN: builds the sticky protocol-violation detector on o_err.
module cdrive_sync_receiver #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       i_drive,
   input  logic [DATA_W-1:0]          i_data,
   output logic                       o_free,
   output logic                       o_valid,
   output logic [DATA_W-1:0]          o_data,
   input  logic                       i_ready,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_err
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] Full = CW'(DEPTH);

   typedef enum logic {StIdle, StHold} state_e;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   drive_dly_q;
   logic                   req;
   logic                   pop;
   logic                   push;
   logic                   full;

   logic [DATA_W-1:0]      mem_q [DEPTH];
   logic [PW-1:0]          wr_ptr_q;
   logic [PW-1:0]          rd_ptr_q;
   logic [PW-1:0]          rd_ptr_d;
   logic [CW-1:0]          count_q;
   logic [CW-1:0]          count_d;
   logic                   valid_q;
   logic                   valid_d;
   logic [DATA_W-1:0]      data_q;
   logic [DATA_W-1:0]      data_d;

   state_e                 state_q;
   state_e                 state_d;
   logic                   free_toggle;
   logic                   toggle_q;
   logic                   free_q;

   // Synchronize the request phase and keep a delayed copy for edge detection
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q      <= '0;
         drive_dly_q <= 1'b0;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], i_drive};
         drive_dly_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign req  = sync_q[SYNC_STAGES-1] ^ drive_dly_q;
   assign pop  = valid_q & i_ready;
   assign full = (count_q == Full);
   // A request into a full FIFO is only accepted if a pop frees the slot on the same edge
   assign push = req & (~full | pop);

   // Next occupancy, read pointer and registered head word
   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      rd_ptr_d = rd_ptr_q + PW'(pop);
      // A word written on this edge becomes visible one edge later
      valid_d  = (count_q - CW'(pop)) != '0;
      data_d   = valid_d ? mem_q[rd_ptr_d] : data_q;
   end

   // Storage array; contents are only meaningful under the pointers, so no reset
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= i_data;
      end
   end

   // Pointers, occupancy and head-word registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         data_q   <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
      end
   end

   // Free-generation state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Free-generation next state: hold the acknowledge once the last slot is taken
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (push && (count_d == Full)) state_d = StHold;
         StHold:  if (pop) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Free-generation output: request an acknowledge toggle for the next edge
   always_comb begin
      free_toggle = 1'b0;
      case (state_q)
         StIdle:  free_toggle = push && (count_d != Full);
         StHold:  free_toggle = pop;
         default: free_toggle = 1'b0;
      endcase
   end

   // Apply the acknowledge toggle one edge after it was decided
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         toggle_q <= 1'b0;
         free_q   <= 1'b0;
      end else begin
         toggle_q <= free_toggle;
         free_q   <= free_q ^ toggle_q;
      end
   end

`ifdef CDRV_RX_ERR_EN
   logic viol;
   logic err_q;

   assign viol = req & full & ~pop;

   // Sticky violation flag, cleared only by reset
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_q <= 1'b0;
      end else if (viol) begin
         err_q <= 1'b1;
      end
   end

   assign o_err = err_q;
`else
   assign o_err = 1'b0;
`endif

   assign o_free  = free_q;
   assign o_valid = valid_q;
   assign o_data  = data_q;
   assign o_count = count_q;

endmodule

// File: tb/tb_cdrive_sync_receiver.sv
// Bench for cdrive_sync_receiver: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based model of the handshake and FIFO behaviour.
module tb_cdrive_sync_receiver;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int S     = 2;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rstn;
   logic          i_drive;
   logic [DW-1:0] i_data;
   logic          o_free;
   logic          o_valid;
   logic [DW-1:0] o_data;
   logic          i_ready;
   logic [CW-1:0] o_count;
   logic          o_err;

   cdrive_sync_receiver #(
      .DATA_W      (DW),
      .DEPTH       (DEPTH),
      .SYNC_STAGES (S)
   ) dut (
      .clk     (clk),
      .rstn    (rstn),
      .i_drive (i_drive),
      .i_data  (i_data),
      .o_free  (o_free),
      .o_valid (o_valid),
      .o_data  (o_data),
      .i_ready (i_ready),
      .o_count (o_count),
      .o_err   (o_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      int            e;
   } ent_t;

   // Reference model state
   ent_t q[$];
   int   sched[$];
   int   free_due[$];
   bit   held;
   bit   exp_free;
   bit   exp_err;
   bit   exp_valid;
   int   n;

   int n_vec;
   int n_bad;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      q.delete();
      sched.delete();
      free_due.delete();
      held      = 1'b0;
      exp_free  = 1'b0;
      exp_err   = 1'b0;
      exp_valid = 1'b0;
   endtask

   // Advance one edge, update the model from the rules, then compare away from the edge
   task automatic tick();
      bit   pop;
      bit   req;
      bit   full;
      ent_t ne;
      @(posedge clk);
      n++;
      pop = exp_valid && (i_ready === 1'b1);
      req = 1'b0;
      if (sched.size() > 0 && sched[0] == n) begin
         req = 1'b1;
         void'(sched.pop_front());
      end
      full = (q.size() == DEPTH);
      if (pop) begin
         void'(q.pop_front());
         if (held) begin
            held = 1'b0;
            free_due.push_back(n + 1);
         end
      end
      if (req) begin
         if (full && !pop) begin
`ifdef CDRV_RX_ERR_EN
            exp_err = 1'b1;
`endif
         end else begin
            ne.d = i_data;
            ne.e = n;
            q.push_back(ne);
            if (q.size() == DEPTH) held = 1'b1;
            else free_due.push_back(n + 1);
         end
      end
      if (free_due.size() > 0 && free_due[0] == n) begin
         exp_free = ~exp_free;
         void'(free_due.pop_front());
      end
      exp_valid = (q.size() > 0) && (q[0].e < n);
      #1;
      chk("valid", 64'(o_valid), 64'(exp_valid));
      chk("count", 64'(o_count), 64'(q.size()));
      chk("free", 64'(o_free), 64'(exp_free));
      chk("err", 64'(o_err), 64'(exp_err));
      if (exp_valid) chk("data", 64'(o_data), 64'(q[0].d));
   endtask

   task automatic ticks(input int k);
      for (int i = 0; i < k; i++) tick();
   endtask

   // Upstream offers a word: toggle the request phase with the bundled data
   task automatic send(input logic [DW-1:0] d);
      i_data  = d;
      i_drive = ~i_drive;
      sched.push_back(n + S + 1);
   endtask

   task automatic wait_free(input int bound, input bit rnd, output int lat);
      logic start;
      start = o_free;
      lat   = 0;
      while (o_free === start && lat < bound) begin
         if (rnd) i_ready = 1'($urandom_range(0, 1));
         tick();
         lat++;
      end
      if (rnd) i_ready = 1'b0;
      chk("free_timeout", 64'(o_free !== start), 64'd1);
   endtask

   task automatic do_reset();
      rstn    = 1'b0;
      i_drive = 1'b0;
      i_ready = 1'b0;
      #1;
      model_clear();
      chk("rst_free", 64'(o_free), 64'd0);
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_data", 64'(o_data), 64'd0);
      chk("rst_count", 64'(o_count), 64'd0);
      chk("rst_err", 64'(o_err), 64'd0);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      int lat;
      int seq;
      n       = 0;
      n_vec   = 0;
      n_bad   = 0;
      rstn    = 1'b0;
      i_drive = 1'b0;
      i_data  = '0;
      i_ready = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      ticks(10);

      // Single word: drive-to-free latency and head presentation
      send(32'hA5A5_0001);
      wait_free(20, 1'b0, lat);
      chk("drive_to_free_lat", 64'(lat), 64'(S + 2));
      chk("single_data", 64'(o_data), 64'hA5A5_0001);
      chk("single_count", 64'(o_count), 64'd1);
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      ticks(2);

      // Fill: three acknowledges, the fourth withheld until a pop
      for (int i = 0; i < 3; i++) begin
         send(32'h1000_0000 + 32'(i));
         wait_free(20, 1'b0, lat);
      end
      send(32'h1000_0003);
      ticks(12);
      chk("fill_count", 64'(o_count), 64'd4);
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      tick();
      chk("fill_release_count", 64'(o_count), 64'd3);

      // Refill to full, then an illegal extra request
      send(32'h1000_0004);
      ticks(8);
      send(32'hDEAD_BEEF);
      ticks(8);
      chk("viol_count", 64'(o_count), 64'd4);
      i_ready = 1'b1;
      ticks(6);
      i_ready = 1'b0;
      ticks(3);

      do_reset();
      ticks(3);

      // Simultaneous push and pop at occupancy two
      send(32'h2000_0001);
      wait_free(20, 1'b0, lat);
      send(32'h2000_0002);
      wait_free(20, 1'b0, lat);
      send(32'h2000_0003);
      ticks(S);
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      chk("pushpop_count", 64'(o_count), 64'd2);
      i_ready = 1'b1;
      ticks(5);
      i_ready = 1'b0;

      // Sequential words across pointer wrap with random consumer back-pressure
      seq = 1;
      for (int i = 0; i < 12; i++) begin
         send(32'(seq));
         seq++;
         wait_free(80, 1'b1, lat);
         ticks($urandom_range(0, 2));
      end
      // Random data traffic
      for (int i = 0; i < 16; i++) begin
         send($urandom);
         wait_free(80, 1'b1, lat);
         ticks($urandom_range(0, 3));
      end
      i_ready = 1'b1;
      ticks(8);
      i_ready = 1'b0;

      // Reset with three words buffered and the held acknowledge just scheduled
      for (int i = 0; i < 3; i++) begin
         send(32'h3000_0000 + 32'(i));
         wait_free(20, 1'b0, lat);
      end
      send(32'h3000_0003);
      ticks(6);
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      chk("pre_reset_count", 64'(o_count), 64'd3);
      #2;
      do_reset();
      ticks(10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
